// File: rtl/vga_temporizador_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and types.
// The renderer imports this package too, so X_INICIO/Y_INICIO stay in one place.
package vga_temporizador_pkg;

   // Width of the pixel counters.
   localparam int LARGURA = 10;

   // Default horizontal segments, in order: sync, back porch, visible, front porch.
   localparam int H_SYNC_PADRAO    = 96;
   localparam int H_BACK_PADRAO    = 48;
   localparam int H_VISIVEL_PADRAO = 640;
   localparam int H_FRONT_PADRAO   = 16;

   // Default vertical segments, in order: sync, back porch, visible, front porch.
   localparam int V_SYNC_PADRAO    = 2;
   localparam int V_BACK_PADRAO    = 33;
   localparam int V_VISIVEL_PADRAO = 480;
   localparam int V_FRONT_PADRAO   = 10;

   localparam int H_TOTAL = H_SYNC_PADRAO + H_BACK_PADRAO + H_VISIVEL_PADRAO + H_FRONT_PADRAO;
   localparam int V_TOTAL = V_SYNC_PADRAO + V_BACK_PADRAO + V_VISIVEL_PADRAO + V_FRONT_PADRAO;

   // First visible pixel in raw counter coordinates.
   localparam int X_INICIO = H_SYNC_PADRAO + H_BACK_PADRAO;
   localparam int Y_INICIO = V_SYNC_PADRAO + V_BACK_PADRAO;

   // Signals that travel together through the delay line to match renderer latency.
   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic visivel;
   } sinais_t;

   // Idle state of the delayed outputs: syncs inactive (high), blanking active.
   localparam sinais_t SINAIS_RESET = '{hs_n: 1'b1, vs_n: 1'b1, visivel: 1'b0};

   // Inclusive range test used by the visible-area decode.
   function automatic logic no_intervalo(input logic [LARGURA-1:0] valor,
                                         input logic [LARGURA-1:0] inicio,
                                         input logic [LARGURA-1:0] fim);
      return (valor >= inicio) && (valor <= fim);
   endfunction

endpackage

// File: rtl/vga_temporizador_linha_atraso.sv
// Generic shift-register delay line with asynchronous reset to a chosen value.
// PROFUNDIDADE=0 degenerates to a plain wire.
module linha_atraso
   import vga_temporizador_pkg::*;
#(
   parameter int                   LARGURA      = 1,
   parameter int                   PROFUNDIDADE = 1,
   parameter logic [LARGURA-1:0]   VALOR_RESET  = '0
) (
   input  logic               VGA_CLK,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   output logic [LARGURA-1:0] saida
);

   generate
      if (PROFUNDIDADE == 0) begin : g_fio
         assign saida = entrada;
      end else begin : g_registros
         logic [LARGURA-1:0] estagio [PROFUNDIDADE];

         // Shift the input through PROFUNDIDADE stages; every stage idles at VALOR_RESET.
         // NOTE: each stage is reset, unlike a RAM, so no stale sync pulse escapes after reset.
         always_ff @(posedge VGA_CLK or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < PROFUNDIDADE; i++) estagio[i] <= VALOR_RESET;
            end else begin
               estagio[0] <= entrada;
               for (int i = 1; i < PROFUNDIDADE; i++) estagio[i] <= estagio[i-1];
            end
         end

         assign saida = estagio[PROFUNDIDADE-1];
      end
   endgenerate

endmodule

// File: rtl/vga_temporizador.sv
// VGA timing generator: raw pixel counters, sync/blank decode delayed to match the
// renderer's registered RGB, an end-of-visible pulse and a completed-frame counter.
module vga_temporizador
   import vga_temporizador_pkg::*;
#(
   parameter int H_SYNC    = H_SYNC_PADRAO,
   parameter int H_BACK    = H_BACK_PADRAO,
   parameter int H_VISIVEL = H_VISIVEL_PADRAO,
   parameter int H_FRONT   = H_FRONT_PADRAO,
   parameter int V_SYNC    = V_SYNC_PADRAO,
   parameter int V_BACK    = V_BACK_PADRAO,
   parameter int V_VISIVEL = V_VISIVEL_PADRAO,
   parameter int V_FRONT   = V_FRONT_PADRAO,
   parameter int ATRASO    = 1
) (
   input  logic               VGA_CLK,
   input  logic               reset,
   output logic [LARGURA-1:0] VGA_X,
   output logic [LARGURA-1:0] VGA_Y,
   output logic               visivel,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK_N,
   output logic               VGA_SYNC_N,
   output logic               fim_visivel,
   output logic [15:0]        contador_quadros
);

   // Segment boundaries in raw counter coordinates, all derived from the parameters.
   localparam int H_TOT = H_SYNC + H_BACK + H_VISIVEL + H_FRONT;
   localparam int V_TOT = V_SYNC + V_BACK + V_VISIVEL + V_FRONT;

   localparam logic [LARGURA-1:0] X_MAX     = LARGURA'(H_TOT - 1);
   localparam logic [LARGURA-1:0] Y_MAX     = LARGURA'(V_TOT - 1);
   localparam logic [LARGURA-1:0] X_SYNC    = LARGURA'(H_SYNC);
   localparam logic [LARGURA-1:0] Y_SYNC    = LARGURA'(V_SYNC);
   localparam logic [LARGURA-1:0] X_VIS_INI = LARGURA'(H_SYNC + H_BACK);
   localparam logic [LARGURA-1:0] X_VIS_FIM = LARGURA'(H_SYNC + H_BACK + H_VISIVEL - 1);
   localparam logic [LARGURA-1:0] Y_VIS_INI = LARGURA'(V_SYNC + V_BACK);
   localparam logic [LARGURA-1:0] Y_VIS_FIM = LARGURA'(V_SYNC + V_BACK + V_VISIVEL - 1);

   logic    fim_linha;
   logic    fim_quadro;
   sinais_t decodificado;
   sinais_t atrasado;

   assign fim_linha  = (VGA_X == X_MAX);
   assign fim_quadro = fim_linha && (VGA_Y == Y_MAX);

   // Raster scan: X every clock, Y at end of line, both wrap at end of frame.
   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset) begin
         VGA_X <= '0;
         VGA_Y <= '0;
      end else if (fim_linha) begin
         VGA_X <= '0;
         VGA_Y <= fim_quadro ? '0 : VGA_Y + 1'b1;
      end else begin
         VGA_X <= VGA_X + 1'b1;
      end
   end

   // Count completed frames; the 16-bit counter wraps naturally.
   always_ff @(posedge VGA_CLK or posedge reset) begin
      if (reset) begin
         contador_quadros <= '0;
      end else if (fim_quadro) begin
         contador_quadros <= contador_quadros + 16'd1;
      end
   end

   // Decode syncs, visible area and the end-of-visible pulse from the registered counters.
   // NOTE: every output is given a default first so no path through the block can infer a latch.
   always_comb begin
      decodificado         = SINAIS_RESET;
      fim_visivel          = 1'b0;
      decodificado.hs_n    = !(VGA_X < X_SYNC);
      decodificado.vs_n    = !(VGA_Y < Y_SYNC);
      decodificado.visivel = no_intervalo(VGA_X, X_VIS_INI, X_VIS_FIM) &&
                             no_intervalo(VGA_Y, Y_VIS_INI, Y_VIS_FIM);
      if ((VGA_X == X_VIS_FIM) && (VGA_Y == Y_VIS_FIM)) fim_visivel = 1'b1;
   end

   assign visivel = decodificado.visivel;

   linha_atraso #(
      .LARGURA      ($bits(sinais_t)),
      .PROFUNDIDADE (ATRASO),
      .VALOR_RESET  (SINAIS_RESET)
   ) u_atraso (
      .VGA_CLK (VGA_CLK),
      .reset   (reset),
      .entrada (decodificado),
      .saida   (atrasado)
   );

   assign VGA_HS      = atrasado.hs_n;
   assign VGA_VS      = atrasado.vs_n;
   assign VGA_BLANK_N = atrasado.visivel;
   assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_temporizador.sv
// Directed bench for vga_temporizador: real horizontal timing, shortened vertical
// timing (V_TOTAL=11, visible lines 5..8) so a full frame takes 8800 cycles.
module tb_vga_temporizador;

   logic       VGA_CLK = 1'b0;
   logic       reset   = 1'b1;
   logic [9:0] VGA_X;
   logic [9:0] VGA_Y;
   logic       visivel;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic       fim_visivel;
   logic [15:0] contador_quadros;

   int checks = 0;
   int errors = 0;

   vga_temporizador #(
      .H_SYNC(96), .H_BACK(48), .H_VISIVEL(640), .H_FRONT(16),
      .V_SYNC(2),  .V_BACK(3),  .V_VISIVEL(4),   .V_FRONT(2),
      .ATRASO(1)
   ) dut (
      .VGA_CLK          (VGA_CLK),
      .reset            (reset),
      .VGA_X            (VGA_X),
      .VGA_Y            (VGA_Y),
      .visivel          (visivel),
      .VGA_HS           (VGA_HS),
      .VGA_VS           (VGA_VS),
      .VGA_BLANK_N      (VGA_BLANK_N),
      .VGA_SYNC_N       (VGA_SYNC_N),
      .fim_visivel      (fim_visivel),
      .contador_quadros (contador_quadros)
   );

   always #5 VGA_CLK = ~VGA_CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Watchdog: the directed sequence is a few tens of thousands of cycles.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   int hs_low_linha0, vs_low_quadro, blank_alto_quadro, blank_alto_linha5;
   int subidas_blank, x_primeira_subida, pulsos_fim, fim_x, fim_y;
   logic blank_ant;

   initial begin
      hs_low_linha0 = 0; vs_low_quadro = 0; blank_alto_quadro = 0; blank_alto_linha5 = 0;
      subidas_blank = 0; x_primeira_subida = -1; pulsos_fim = 0; fim_x = -1; fim_y = -1;
      blank_ant = 1'b0;

      // Hold reset for 5 cycles, release on a falling edge.
      repeat (5) @(posedge VGA_CLK);
      @(negedge VGA_CLK);
      check("reset_hs", VGA_HS, 1);
      check("reset_vs", VGA_VS, 1);
      check("reset_blank", VGA_BLANK_N, 0);
      check("sync_n_tied", VGA_SYNC_N, 0);
      reset = 1'b0;

      // Sample k is taken k falling edges after release; X = k mod 800 in the first frame.
      for (int k = 0; k <= 8800; k++) begin
         if (k < 8800) begin
            if (k < 800 && !VGA_HS) hs_low_linha0++;
            if (!VGA_VS) vs_low_quadro++;
            if (VGA_BLANK_N) blank_alto_quadro++;
            if (k >= 4000 && k < 4800 && VGA_BLANK_N) blank_alto_linha5++;
            if (VGA_BLANK_N && !blank_ant) begin
               subidas_blank++;
               if (x_primeira_subida < 0) x_primeira_subida = int'(VGA_X);
            end
            blank_ant = VGA_BLANK_N;
            if (fim_visivel) begin
               pulsos_fim++;
               fim_x = int'(VGA_X);
               fim_y = int'(VGA_Y);
            end
         end

         case (k)
            0: begin
               check("first_x", VGA_X, 0);
               check("first_y", VGA_Y, 0);
               check("first_hs_still_reset", VGA_HS, 1);
               check("first_vs_still_reset", VGA_VS, 1);
               check("first_blank", VGA_BLANK_N, 0);
               check("first_count", contador_quadros, 0);
            end
            1: begin
               check("second_x", VGA_X, 1);
               check("second_hs_low", VGA_HS, 0);
               check("second_vs_low", VGA_VS, 0);
               check("second_blank", VGA_BLANK_N, 0);
            end
            800:  check("hs_end_line0_high", VGA_HS, 1);
            801:  check("hs_line1_low", VGA_HS, 0);
            1600: check("vs_last_low", VGA_VS, 0);
            1601: check("vs_first_high", VGA_VS, 1);
            4096: check("hs_x96_low", VGA_HS, 0);
            4097: check("hs_x97_high", VGA_HS, 1);
            4143: check("visivel_x143", visivel, 0);
            4144: begin
               check("visivel_x144", visivel, 1);
               check("visivel_x144_y", VGA_Y, 5);
               check("blank_x144_still_low", VGA_BLANK_N, 0);
            end
            4145: check("blank_x145_high", VGA_BLANK_N, 1);
            4783: check("visivel_x783", visivel, 1);
            4784: check("visivel_x784", visivel, 0);
            4785: check("blank_x785_low", VGA_BLANK_N, 0);
            8799: begin
               check("last_x", VGA_X, 799);
               check("last_y", VGA_Y, 10);
               check("count_before_wrap", contador_quadros, 0);
            end
            8800: begin
               check("frame_x_wrap", VGA_X, 0);
               check("frame_y_wrap", VGA_Y, 0);
               check("frame_count", contador_quadros, 1);
            end
            default: ;
         endcase
         if (k < 8800) @(negedge VGA_CLK);
      end

      check("hs_low_per_line", hs_low_linha0, 96);
      check("vs_low_per_frame", vs_low_quadro, 1600);
      check("blank_line5_len", blank_alto_linha5, 640);
      check("blank_frame_total", blank_alto_quadro, 2560);
      check("blank_rises", subidas_blank, 4);
      check("blank_first_rise_x", x_primeira_subida, 145);
      check("fim_pulses", pulsos_fim, 1);
      check("fim_x", fim_x, 783);
      check("fim_y", fim_y, 8);

      // Advance to X=400, Y=7 of the second frame (sample 8800 + 7*800 + 400).
      repeat (6000) @(negedge VGA_CLK);
      check("mid_x", VGA_X, 400);
      check("mid_y", VGA_Y, 7);
      check("mid_blank", VGA_BLANK_N, 1);

      // Asynchronous reset between clock edges clears everything immediately.
      #2 reset = 1'b1;
      #1;
      check("async_x", VGA_X, 0);
      check("async_y", VGA_Y, 0);
      check("async_count", contador_quadros, 0);
      check("async_hs", VGA_HS, 1);
      check("async_vs", VGA_VS, 1);
      check("async_blank", VGA_BLANK_N, 0);
      @(negedge VGA_CLK);
      check("held_x", VGA_X, 0);
      check("held_hs", VGA_HS, 1);
      reset = 1'b0;
      @(negedge VGA_CLK);
      check("restart_x", VGA_X, 1);
      check("restart_y", VGA_Y, 0);
      check("restart_hs", VGA_HS, 0);
      check("restart_vs", VGA_VS, 0);
      check("restart_blank", VGA_BLANK_N, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
